// File: rtl/game_pkg.sv
// Constants shared by the input-conditioning stage and game_logic.
package game_pkg;

  localparam int unsigned NUM_BTN     = 4;
  localparam int unsigned BTN_IDX_W   = 2;
  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/btn_chan.sv
// One button channel: polarity fix, 2-FF synchroniser, stability counter and
// registered debounced level with a press-edge flag.
module btn_chan #(
  parameter int unsigned DebounceCycles = 8,
  parameter bit          ActiveLow      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned           CntW   = $clog2(DebounceCycles);
  localparam logic [CntW-1:0]       CntMax = CntW'(DebounceCycles - 1);

  logic            pressed;
  logic [1:0]      sync_q;
  logic            stable;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q;

  assign pressed = ActiveLow ? ~btn_raw_i : btn_raw_i;
  assign stable  = sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (stable == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = stable;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pressed};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  // High for the one cycle after the level rose; the top registers it into the pulse.
  assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces the raw push-buttons and emits gated one-cycle press pulses plus
// an arbitrated single-press strobe with its binary index.
module btn_debouncer #(
  parameter int unsigned NUM_BTN         = game_pkg::NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_BTN-1:0]            btn_raw,
  input  logic                          enable,
  output logic [NUM_BTN-1:0]            btn_level,
  output logic [NUM_BTN-1:0]            btn_pulse,
  output logic                          press_valid,
  output logic [game_pkg::BTN_IDX_W-1:0] press_idx,
  output logic                          press_multi
);

  import game_pkg::*;

  logic [NUM_BTN-1:0]   rise;
  logic [NUM_BTN-1:0]   hit;
  logic [NUM_BTN-1:0]   pulse_q, pulse_d;
  logic                 valid_q, valid_d;
  logic                 multi_q, multi_d;
  logic [BTN_IDX_W-1:0] idx_q, idx_d;
  logic [BTN_IDX_W-1:0] idx_any;
  int unsigned          hit_cnt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_chan #(
      .DebounceCycles (DEBOUNCE_CYCLES),
      .ActiveLow      (ACTIVE_LOW)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .btn_raw_i (btn_raw[g]),
      .level_o   (btn_level[g]),
      .rise_o    (rise[g])
    );
  end

  // Edges seen while disabled are dropped, never deferred.
  assign hit = rise & {NUM_BTN{enable}};

  always_comb begin
    hit_cnt = 0;
    idx_any = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (hit[i]) begin
        hit_cnt = hit_cnt + 1;
        idx_any = BTN_IDX_W'(i);
      end
    end
    pulse_d = hit;
    valid_d = (hit_cnt == 1);
    multi_d = (hit_cnt >= 2);
    idx_d   = valid_d ? idx_any : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_q <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      idx_q   <= idx_d;
    end
  end

  assign btn_pulse   = pulse_q;
  assign press_valid = valid_q;
  assign press_multi = multi_q;
  assign press_idx   = idx_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with an 8-cycle debounce window.
module tb_btn_debouncer;

  localparam int unsigned D = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       press_multi;

  int n_tests = 0;
  int n_fail  = 0;

  btn_debouncer #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .press_valid (press_valid),
    .press_idx   (press_idx),
    .press_multi (press_multi)
  );

  always #5 clock = ~clock;

  // {level, pulse, valid, idx, multi}
  logic [11:0] obs;
  assign obs = {btn_level, btn_pulse, press_valid, press_idx, press_multi};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    btn_raw = 4'hF;
    tick();
    tick();
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", obs, 12'h000);
    end
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_tests++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL idle e=%0d got %h exp %h", e, obs, 12'h000);
      end
    end
  endtask

  task automatic release_all(input string name);
    logic [11:0] exp;
    btn_raw = 4'hF;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp = 12'h000;
      n_tests++;
      if (obs[7:0] !== exp[7:0] || (e >= 9 && obs !== exp)) begin
        n_fail++;
        $display("FAIL %s_release e=%0d got %h exp %h", name, e, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] exp;
    btn_raw = 4'b1011;
    for (int e = 0; e < 40; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b0100 : 4'b0000,
             (e == 10) ? 4'b0100 : 4'b0000,
             (e == 10), (e == 10) ? 2'd2 : 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL clean_press e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("clean");
  endtask

  task automatic test_bounce();
    logic [11:0] exp;
    for (int j = 0; j < 10; j++) begin
      btn_raw = (j % 2 == 0) ? 4'b1110 : 4'b1111;
      for (int k = 0; k < 3; k++) begin
        tick();
        n_tests++;
        if (obs !== 12'h000) begin
          n_fail++;
          $display("FAIL bounce_toggle seg=%0d got %h exp %h", j, obs, 12'h000);
        end
      end
    end
    btn_raw = 4'b1110;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b0001 : 4'b0000,
             (e == 10) ? 4'b0001 : 4'b0000,
             (e == 10), 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bounce_settle e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("bounce");
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp;
    btn_raw = 4'b0101;
    for (int e = 0; e < 16; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b1010 : 4'b0000,
             (e == 10) ? 4'b1010 : 4'b0000,
             1'b0, 2'd0, (e == 10)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL simultaneous e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("simul");
  endtask

  task automatic test_enable_gating();
    logic [11:0] exp;
    enable  = 1'b0;
    btn_raw = 4'b1101;
    for (int e = 0; e < 15; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b0010 : 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gated_press e=%0d got %h exp %h", e, obs, exp);
      end
    end
    enable = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp = {4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gated_hold e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("gated");
    btn_raw = 4'b1101;
    for (int e = 0; e < 16; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b0010 : 4'b0000,
             (e == 10) ? 4'b0010 : 4'b0000,
             (e == 10), (e == 10) ? 2'd1 : 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gated_repress e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("repress");
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    // Channel 0 already settled high so the async clear is observable.
    btn_raw = 4'b1110;
    for (int e = 0; e < 12; e++) tick();
    n_tests++;
    if (btn_level !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_setup got %b exp %b", btn_level, 4'b0001);
    end
    btn_raw = 4'b1010;
    for (int e = 0; e < 5; e++) tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_async got %h exp %h", obs, 12'h000);
    end
    btn_raw = 4'b1011;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 0; e < 16; e++) begin
      tick();
      exp = {(e >= 9) ? 4'b0100 : 4'b0000,
             (e == 10) ? 4'b0100 : 4'b0000,
             (e == 10), (e == 10) ? 2'd2 : 2'd0, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_recover e=%0d got %h exp %h", e, obs, exp);
      end
    end
    release_all("reset_mid");
  endtask

  task automatic test_short_glitch();
    btn_raw = 4'b0111;
    for (int e = 0; e < 7; e++) begin
      tick();
      n_tests++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL glitch_low e=%0d got %h exp %h", e, obs, 12'h000);
      end
    end
    btn_raw = 4'hF;
    for (int e = 0; e < 25; e++) begin
      tick();
      n_tests++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL glitch_after e=%0d got %h exp %h", e, obs, 12'h000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_enable_gating();
    test_reset_mid();
    test_short_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

endmodule
